// File: rtl/tnn_sort_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tnn_sort_pkg
// Brief    : Shared types and constants for the TNN sorter scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package tnn_sort_pkg;

    localparam int c_n_lanes = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_WIN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // All-ones spike time means the line never fires.
    function automatic int unsigned no_spike(input int unsigned tw);
        return (32'd1 << tw) - 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tnn_sort_lane_cap.sv
`default_nettype none
// ============================================================================
// Module   : tnn_sort_lane_cap
// Brief    : Per-lane first-fall capture of the sorter output during a window.
// Revision : 1.0 - initial release
// ============================================================================
module tnn_sort_lane_cap
    import tnn_sort_pkg::*;
#(
    parameter int TW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clear,
    input  logic          i_win,
    input  logic          i_last,
    input  logic          i_sort_bit,
    input  logic [TW-1:0] i_t,
    output logic [TW-1:0] o_time,
    output logic [TW-1:0] o_time_nxt
);

    localparam logic [TW-1:0] c_no_spike = TW'(no_spike(TW));

    logic          r_flag;
    logic          w_flag_nxt;
    logic [TW-1:0] r_time;
    logic [TW-1:0] w_time_nxt;

    always_comb begin
        w_flag_nxt = r_flag;
        w_time_nxt = r_time;
        if (i_clear) begin
            w_flag_nxt = 1'b0;
            w_time_nxt = '0;
        end else if (i_win && !r_flag) begin
            if (!i_sort_bit) begin
                w_flag_nxt = 1'b1;
                w_time_nxt = i_t;
            end else if (i_last) begin
                // Lane never fell inside the window.
                w_time_nxt = c_no_spike;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flag <= 1'b0;
            r_time <= '0;
        end else begin
            r_flag <= w_flag_nxt;
            r_time <= w_time_nxt;
        end
    end

    assign o_time     = r_time;
    assign o_time_nxt = w_time_nxt;

endmodule
`default_nettype wire

// File: rtl/tnn_sort_sched.sv
`default_nettype none
// ============================================================================
// Module   : tnn_sort_sched
// Brief    : Drives a 16-input spike sorter through precharge and a time
//            window, capturing the fall time of each sorted output lane.
//            Optional sortedness check: define TNN_SORT_SCHED_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tnn_sort_sched
    import tnn_sort_pkg::*;
#(
    parameter int TW      = 3,
    parameter int PRE_CYC = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [c_n_lanes*TW-1:0]     in_times,
    output logic [15:0]                 sort_raw_in,
    input  logic [15:0]                 sort_out,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [c_n_lanes*TW-1:0]     out_times,
    output logic                        err
);

    localparam logic [TW-1:0] c_no_spike = TW'(no_spike(TW));
    localparam logic [3:0]    c_pre_last = 4'(PRE_CYC - 1);

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [3:0]                r_pre_cnt;
    logic [TW-1:0]             r_t;
    logic [TW-1:0]             w_t_nxt;
    logic [c_n_lanes*TW-1:0]   r_times;
    logic [15:0]               r_raw;
    logic [15:0]               w_raw_nxt;
    logic [c_n_lanes*TW-1:0]   w_cap_nxt;
    logic                      w_accept;
    logic                      w_win;
    logic                      w_win_last;

    assign w_accept   = (r_state == ST_IDLE) && in_valid;
    assign w_win      = (r_state == ST_WIN);
    assign w_win_last = w_win && (r_t == c_no_spike);

    always_comb begin
        w_state_nxt = r_state;
        w_t_nxt     = '0;
        w_raw_nxt   = 16'hFFFF;
        case (r_state)
            ST_IDLE: if (in_valid)                   w_state_nxt = ST_PRE;
            ST_PRE:  if (r_pre_cnt == c_pre_last)    w_state_nxt = ST_WIN;
            ST_WIN:  if (w_win_last)                 w_state_nxt = ST_DONE;
            ST_DONE: if (out_ready)                  w_state_nxt = ST_IDLE;
            default:                                 w_state_nxt = ST_IDLE;
        endcase
        if (w_win && !w_win_last)
            w_t_nxt = r_t + 1'b1;
        // Drive register is loaded for the step about to start, so the sorter
        // sees step t's pattern throughout WIN cycle t.
        if (w_state_nxt == ST_WIN) begin
            for (int i = 0; i < c_n_lanes; i++) begin
                if ((r_times[i*TW +: TW] <= w_t_nxt) && (r_times[i*TW +: TW] != c_no_spike))
                    w_raw_nxt[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_pre_cnt <= '0;
            r_t       <= '0;
            r_times   <= '0;
            r_raw     <= 16'hFFFF;
        end else begin
            r_state   <= w_state_nxt;
            r_t       <= w_t_nxt;
            r_raw     <= w_raw_nxt;
            r_pre_cnt <= (r_state == ST_PRE) ? r_pre_cnt + 4'd1 : 4'd0;
            if (w_accept)
                r_times <= in_times;
        end
    end

    generate
        for (genvar j = 0; j < c_n_lanes; j++) begin : g_lane
            tnn_sort_lane_cap #(
                .TW (TW)
            ) u_cap (
                .clk        (clk),
                .rst        (rst),
                .i_clear    (w_accept),
                .i_win      (w_win),
                .i_last     (w_win_last),
                .i_sort_bit (sort_out[j]),
                .i_t        (r_t),
                .o_time     (out_times[j*TW +: TW]),
                .o_time_nxt (w_cap_nxt[j*TW +: TW])
            );
        end
    endgenerate

`ifdef TNN_SORT_SCHED_CHECK_EN
    logic r_err;
    logic w_viol;

    // Lane 15 holds the earliest time, so times must not grow toward lane 15.
    always_comb begin
        w_viol = 1'b0;
        for (int j = 0; j < c_n_lanes - 1; j++) begin
            if (w_cap_nxt[(j+1)*TW +: TW] > w_cap_nxt[j*TW +: TW])
                w_viol = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_err <= 1'b0;
        else if (w_win_last && w_viol)
            r_err <= 1'b1;
    end

    assign err = r_err;
`else
    logic w_unused_cap;
    assign w_unused_cap = ^w_cap_nxt;
    assign err          = 1'b0;
`endif

    assign in_ready    = (r_state == ST_IDLE);
    assign out_valid   = (r_state == ST_DONE);
    assign sort_raw_in = r_raw;

endmodule
`default_nettype wire

// File: tb/tb_tnn_sort_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_tnn_sort_sched
// Brief    : Self-checking bench for tnn_sort_sched with a behavioural sorter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tnn_sort_sched;

    localparam int            TW      = 3;
    localparam int            PRE_CYC = 2;
    localparam int            NL      = 16;
    localparam int            WIN_LEN = 1 << TW;
    localparam logic [TW-1:0] NS      = 3'd7;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [NL*TW-1:0] in_times = '0;
    logic             in_ready;
    logic             out_valid;
    logic             err;
    logic [15:0]      sort_raw_in;
    logic [15:0]      sort_out;
    logic [NL*TW-1:0] out_times;
    logic             swap = 1'b0;
    logic             exp_err = 1'b0;
    int               total = 0;
    int               bad = 0;

    always #5 clk = ~clk;

    tnn_sort_sched #(
        .TW      (TW),
        .PRE_CYC (PRE_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_times    (in_times),
        .sort_raw_in (sort_raw_in),
        .sort_out    (sort_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_times   (out_times),
        .err         (err)
    );

    // Ideal 16-input sorter: k low inputs give k low outputs packed at the top.
    logic [15:0] w_sorted;
    int          n_low;
    always_comb begin
        n_low = 0;
        for (int i = 0; i < 16; i++)
            if (!sort_raw_in[i]) n_low++;
        w_sorted = 16'hFFFF;
        for (int j = 0; j < 16; j++)
            if (j >= 16 - n_low) w_sorted[j] = 1'b0;
        sort_out = w_sorted;
        if (swap) begin
            sort_out[15] = w_sorted[0];
            sort_out[0]  = w_sorted[15];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: lane 15 gets the smallest time, lane 0 the largest.
    function automatic logic [NL*TW-1:0] model_out(input logic [NL*TW-1:0] tv, input logic sw);
        int               q[$];
        logic [NL*TW-1:0] r;
        logic [TW-1:0]    tmp;
        for (int i = 0; i < NL; i++) q.push_back(int'(tv[i*TW +: TW]));
        q.sort();
        for (int k = 0; k < NL; k++) r[(NL-1-k)*TW +: TW] = TW'(q[k]);
        if (sw) begin
            tmp = r[0 +: TW];
            r[0 +: TW] = r[(NL-1)*TW +: TW];
            r[(NL-1)*TW +: TW] = tmp;
        end
        return r;
    endfunction

    function automatic logic [15:0] model_raw(input logic [NL*TW-1:0] tv, input int t);
        logic [15:0] r;
        for (int i = 0; i < NL; i++)
            r[i] = !((int'(tv[i*TW +: TW]) <= t) && (tv[i*TW +: TW] != NS));
        return r;
    endfunction

    function automatic logic unsorted(input logic [NL*TW-1:0] ot);
        logic v = 1'b0;
        for (int j = 0; j < NL - 1; j++)
            if (ot[(j+1)*TW +: TW] > ot[j*TW +: TW]) v = 1'b1;
        return v;
    endfunction

    function automatic logic [NL*TW-1:0] rand_times();
        logic [NL*TW-1:0] r;
        for (int i = 0; i < NL; i++) r[i*TW +: TW] = TW'($urandom_range(0, 7));
        return r;
    endfunction

    task automatic send_wave(input logic [NL*TW-1:0] tv, input int hold);
        logic [NL*TW-1:0] expo;
        int               cyc;
        expo = model_out(tv, swap);
`ifdef TNN_SORT_SCHED_CHECK_EN
        exp_err = exp_err | unsorted(expo);
`endif
        check("ready_before", in_ready, 1'b1);
        in_valid = 1'b1;
        in_times = tv;
        step();
        in_valid = 1'b0;
        in_times = rand_times();
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            check("ready_busy", in_ready, 1'b0);
            if (cyc >= PRE_CYC && cyc < PRE_CYC + WIN_LEN)
                check("raw_win", sort_raw_in, model_raw(tv, cyc - PRE_CYC));
            else
                check("raw_pre", sort_raw_in, 16'hFFFF);
            step();
            cyc++;
        end
        check("latency", cyc, PRE_CYC + WIN_LEN);
        check("out_times", out_times, expo);
        check("err", err, exp_err);
        check("raw_done", sort_raw_in, 16'hFFFF);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            step();
            check("hold_valid", out_valid, 1'b1);
            check("hold_times", out_times, expo);
            check("hold_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("post_hs_valid", out_valid, 1'b0);
        check("post_hs_ready", in_ready, 1'b1);
        step();
        check("idle_stays", in_ready, 1'b1);
    endtask

    task automatic reset_mid_win(input logic [NL*TW-1:0] tv);
        int seen;
        in_valid = 1'b1;
        in_times = tv;
        step();
        in_valid = 1'b0;
        repeat (PRE_CYC + 3) step();
        check("raw_t3", sort_raw_in, model_raw(tv, 3));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_ready", in_ready, 1'b1);
        check("rst_valid", out_valid, 1'b0);
        check("rst_raw", sort_raw_in, 16'hFFFF);
        check("rst_times", out_times, '0);
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            if (out_valid) seen++;
            step();
        end
        check("no_valid_after_rst", seen, 0);
    endtask

    initial begin
        logic [NL*TW-1:0] tv;
        rst = 1'b1;
        repeat (3) step();
        check("reset_ready", in_ready, 1'b1);
        check("reset_valid", out_valid, 1'b0);
        check("reset_raw", sort_raw_in, 16'hFFFF);
        check("reset_times", out_times, '0);
        check("reset_err", err, 1'b0);
        rst = 1'b0;
        step();

        for (int i = 0; i < NL; i++) tv[i*TW +: TW] = TW'(i % 7);
        send_wave(tv, 0);
        check("mod7_err", err, 1'b0);

        for (int i = 0; i < NL; i++) tv[i*TW +: TW] = NS;
        send_wave(tv, 5);

        for (int w = 0; w < 5; w++) send_wave(rand_times(), int'($urandom_range(0, 3)));

        reset_mid_win(rand_times());
        send_wave(rand_times(), 1);

`ifdef TNN_SORT_SCHED_CHECK_EN
        swap = 1'b1;
        for (int i = 0; i < NL; i++) tv[i*TW +: TW] = NS;
        tv[3*TW +: TW] = 3'd1;
        tv[9*TW +: TW] = 3'd5;
        send_wave(tv, 2);
        check("swap_err_set", err, 1'b1);
        swap = 1'b0;
        send_wave(rand_times(), 0);
        check("err_sticky", err, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_err = 1'b0;
        check("err_cleared", err, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
